// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the ARM-style pipeline: decode control
// word, forwarding select encoding and the PC register address.
package arm_pipe_pkg;

  // R15 reads the PC; it is never written through the pipeline
  localparam logic [3:0] REG_PC = 4'hF;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       branch;
    logic [1:0] alucontrol;
    logic [1:0] flagwrite;
    logic [3:0] cond;
  } ctrl_t;

  // A bubble carries no architectural side effects
  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/idex_stage_hazard_unit.sv
// Hazard detection for the D->E boundary: register address compares,
// WB-to-D bypass selects, E-stage forwarding selects, load-use and branch
// stall/flush generation.
// Build option: IDEX_FORWARD_EN enables MEM/WB forwarding into E; without
// it, any RAW against an in-flight writer stalls D until the writer is in WB.
module hazard_unit
  import arm_pipe_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic          reset,
  input  logic [AW-1:0] ra1D,
  input  logic [AW-1:0] ra2D,
  input  logic [AW-1:0] ra1E,
  input  logic [AW-1:0] ra2E,
  input  logic [AW-1:0] wa3E,
  input  logic          regwriteE,
  input  logic          memtoregE,
  input  logic          validE,
  input  logic [AW-1:0] wa3M,
  input  logic          regwriteM,
  input  logic [AW-1:0] wa3W,
  input  logic          regwriteW,
  input  logic          branchtakenE,
  output fwd_sel_e      fwd_a,
  output fwd_sel_e      fwd_b,
  output logic          byp1D,
  output logic          byp2D,
  output logic          stallF,
  output logic          stallD,
  output logic          flushD,
  output logic          flushE
);

  localparam logic [AW-1:0] PC_ADDR = AW'(REG_PC);

  // A read address matches a pending write; the PC is never a match
  function automatic logic hit(input logic [AW-1:0] ra,
                               input logic [AW-1:0] wa,
                               input logic          we);
    return we && (ra == wa) && (ra != PC_ADDR);
  endfunction

  logic ldstall;
  logic raw_stall;

`ifdef IDEX_FORWARD_EN
  // E-stage operand source select, MEM result takes priority over WB
  always_comb begin
    fwd_a = FWD_NONE;
    fwd_b = FWD_NONE;
    if (hit(ra1E, wa3M, regwriteM))      fwd_a = FWD_MEM;
    else if (hit(ra1E, wa3W, regwriteW)) fwd_a = FWD_WB;
    if (hit(ra2E, wa3M, regwriteM))      fwd_b = FWD_MEM;
    else if (hit(ra2E, wa3W, regwriteW)) fwd_b = FWD_WB;
  end

  assign raw_stall = 1'b0;
`else
  // No forwarding paths: hold D while a writer sits in E or M
  assign fwd_a = FWD_NONE;
  assign fwd_b = FWD_NONE;
  assign raw_stall = hit(ra1D, wa3E, regwriteE && validE) ||
                     hit(ra2D, wa3E, regwriteE && validE) ||
                     hit(ra1D, wa3M, regwriteM) ||
                     hit(ra2D, wa3M, regwriteM);

  logic unused_e_addr;
  assign unused_e_addr = ^{ra1E, ra2E};
`endif

  // WB-to-D bypass, load-use detection and the resulting stall/flush
  always_comb begin
    byp1D   = hit(ra1D, wa3W, regwriteW);
    byp2D   = hit(ra2D, wa3W, regwriteW);
    ldstall = memtoregE && validE &&
              (hit(ra1D, wa3E, 1'b1) || hit(ra2D, wa3E, 1'b1));
    stallF  = !reset && (ldstall || raw_stall);
    stallD  = !reset && (ldstall || raw_stall);
    flushD  = !reset && branchtakenE;
    flushE  = ldstall || raw_stall || branchtakenE;
  end

endmodule

// File: rtl/idex_stage.sv
// Decode-to-execute pipeline register with RAW hazard handling: captures
// operands (with WB-to-D bypass), immediate, addresses and control into E,
// forwards MEM/WB results onto the E operands and inserts bubbles on
// load-use stalls and taken branches.
// Build option: IDEX_FORWARD_EN (see hazard_unit) selects forwarding versus
// stall-until-WB; the default build has forwarding disabled.
module idex_stage
  import arm_pipe_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] rd1D,
  input  logic [DW-1:0] rd2D,
  input  logic [AW-1:0] ra1D,
  input  logic [AW-1:0] ra2D,
  input  logic [AW-1:0] wa3D,
  input  logic [DW-1:0] extimmD,
  input  ctrl_t         ctrlD,
  input  logic [DW-1:0] aluresultM,
  input  logic [AW-1:0] wa3M,
  input  logic          regwriteM,
  input  logic [DW-1:0] resultW,
  input  logic [AW-1:0] wa3W,
  input  logic          regwriteW,
  input  logic          branchtakenE,
  output logic [DW-1:0] srcAE,
  output logic [DW-1:0] writedataE,
  output logic [DW-1:0] extimmE,
  output logic [AW-1:0] wa3E,
  output ctrl_t         ctrlE,
  output logic          validE,
  output logic          stallF,
  output logic          stallD,
  output logic          flushD
);

  logic [DW-1:0] rd1E_d, rd1E_q;
  logic [DW-1:0] rd2E_d, rd2E_q;
  logic [DW-1:0] extimmE_d, extimmE_q;
  logic [AW-1:0] ra1E_d, ra1E_q;
  logic [AW-1:0] ra2E_d, ra2E_q;
  logic [AW-1:0] wa3E_d, wa3E_q;
  ctrl_t         ctrlE_d, ctrlE_q;
  logic          validE_d, validE_q;

  fwd_sel_e fwd_a;
  fwd_sel_e fwd_b;
  logic     byp1D;
  logic     byp2D;
  logic     flushE;

  hazard_unit #(.AW(AW)) u_hazard (
    .reset        (reset),
    .ra1D         (ra1D),
    .ra2D         (ra2D),
    .ra1E         (ra1E_q),
    .ra2E         (ra2E_q),
    .wa3E         (wa3E_q),
    .regwriteE    (ctrlE_q.regwrite),
    .memtoregE    (ctrlE_q.memtoreg),
    .validE       (validE_q),
    .wa3M         (wa3M),
    .regwriteM    (regwriteM),
    .wa3W         (wa3W),
    .regwriteW    (regwriteW),
    .branchtakenE (branchtakenE),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .byp1D        (byp1D),
    .byp2D        (byp2D),
    .stallF       (stallF),
    .stallD       (stallD),
    .flushD       (flushD),
    .flushE       (flushE)
  );

  // Next E contents: D fields with same-edge WB bypass, or a bubble on flush
  always_comb begin
    // NOTE: every always_comb output is assigned up front so no path can
    // leave it holding its old value, which would infer a latch.
    rd1E_d    = byp1D ? resultW : rd1D;
    rd2E_d    = byp2D ? resultW : rd2D;
    extimmE_d = extimmD;
    ra1E_d    = ra1D;
    ra2E_d    = ra2D;
    wa3E_d    = wa3D;
    ctrlE_d   = ctrlD;
    validE_d  = 1'b1;
    if (flushE) begin
      rd1E_d    = '0;
      rd2E_d    = '0;
      extimmE_d = '0;
      ra1E_d    = '0;
      ra2E_d    = '0;
      wa3E_d    = '0;
      ctrlE_d   = CTRL_BUBBLE;
      validE_d  = 1'b0;
    end
  end

  // D/E pipeline register, cleared to a bubble by reset
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state updates use non-blocking assignments so every flop samples
    // its _d value from before the edge, independent of statement order.
    if (reset) begin
      rd1E_q    <= '0;
      rd2E_q    <= '0;
      extimmE_q <= '0;
      ra1E_q    <= '0;
      ra2E_q    <= '0;
      wa3E_q    <= '0;
      ctrlE_q   <= CTRL_BUBBLE;
      validE_q  <= 1'b0;
    end else begin
      rd1E_q    <= rd1E_d;
      rd2E_q    <= rd2E_d;
      extimmE_q <= extimmE_d;
      ra1E_q    <= ra1E_d;
      ra2E_q    <= ra2E_d;
      wa3E_q    <= wa3E_d;
      ctrlE_q   <= ctrlE_d;
      validE_q  <= validE_d;
    end
  end

  // Operand forwarding muxes; forced to zero while reset is held
  always_comb begin
    case (fwd_a)
      FWD_MEM: srcAE = aluresultM;
      FWD_WB:  srcAE = resultW;
      default: srcAE = rd1E_q;
    endcase
    case (fwd_b)
      FWD_MEM: writedataE = aluresultM;
      FWD_WB:  writedataE = resultW;
      default: writedataE = rd2E_q;
    endcase
    if (reset) begin
      srcAE      = '0;
      writedataE = '0;
    end
  end

  assign extimmE = extimmE_q;
  assign wa3E    = wa3E_q;
  assign ctrlE   = ctrlE_q;
  assign validE  = validE_q;

endmodule
